// File: rtl/mem_stage_controller_pkg.sv
// Shared definitions for the MEM-stage controller: funct5/funct3 codes, FSM state
// encoding and the load/store lane helpers.
package mem_defs;

  localparam logic [4:0] ATOMIC_ADD   = 5'b00000;
  localparam logic [4:0] ATOMIC_SWAP  = 5'b00001;
  localparam logic [4:0] ATOMIC_LR    = 5'b00010;
  localparam logic [4:0] ATOMIC_SC    = 5'b00011;
  localparam logic [4:0] ATOMIC_XOR   = 5'b00100;
  localparam logic [4:0] ATOMIC_OR    = 5'b01000;
  localparam logic [4:0] ATOMIC_AND   = 5'b01100;
  localparam logic [4:0] ATOMIC_MIN   = 5'b10000;
  localparam logic [4:0] ATOMIC_MAX   = 5'b10100;
  localparam logic [4:0] ATOMIC_MINU  = 5'b11000;
  localparam logic [4:0] ATOMIC_MAXU  = 5'b11100;
  localparam logic [4:0] ATOMIC_NO_OP = 5'b11111;

  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_AMO_RD = 3'd2,
    ST_AMO_WR = 3'd3,
    ST_DONE   = 3'd4
  } mem_state_t;

  function automatic logic is_misaligned(input logic [2:0] len, input logic [1:0] off);
    case (len)
      LEN_B, LEN_BU: return 1'b0;
      LEN_H, LEN_HU: return off[0];
      default:       return off != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] len);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (len)
      LEN_B:   return {{24{sh[7]}}, sh[7:0]};
      LEN_BU:  return {24'h0, sh[7:0]};
      LEN_H:   return {{16{sh[15]}}, sh[15:0]};
      LEN_HU:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] rs2, input logic [2:0] len);
    case (len)
      LEN_B, LEN_BU: return {4{rs2[7:0]}};
      LEN_H, LEN_HU: return {2{rs2[15:0]}};
      default:       return rs2;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] off, input logic [2:0] len);
    case (len)
      LEN_B, LEN_BU: return 4'b0001 << off;
      LEN_H, LEN_HU: return 4'b0011 << off;
      default:       return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_controller_if.sv
// Single-outstanding request/ready data bus between the MEM stage and data memory.
interface mem_stage_controller_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_stage_controller_amo_alu.sv
// Combinational read-modify-write operator for RV32A AMOs: new = op(old, rs2).
module amo_alu
  import mem_defs::*;
(
  input  logic [31:0] old,
  input  logic [31:0] rs2,
  input  logic [4:0]  funct5,
  output logic [31:0] result
);

  always_comb begin
    result = old;
    case (funct5)
      ATOMIC_ADD:  result = old + rs2;
      ATOMIC_SWAP: result = rs2;
      ATOMIC_XOR:  result = old ^ rs2;
      ATOMIC_AND:  result = old & rs2;
      ATOMIC_OR:   result = old | rs2;
      ATOMIC_MIN:  result = ($signed(old) < $signed(rs2)) ? old : rs2;
      ATOMIC_MAX:  result = ($signed(old) > $signed(rs2)) ? old : rs2;
      ATOMIC_MINU: result = (old < rs2) ? old : rs2;
      ATOMIC_MAXU: result = (old > rs2) ? old : rs2;
      default:     result = old;
    endcase
  end

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage data access sequencer: bus handshake, pipeline stall, load alignment.
// Define MEM_ATOMIC_EN to build AMO read-modify-write, LR/SC and the reservation.
//
// state     | meaning
// ST_IDLE   | decode pending op; stall while one is present
// ST_ACCESS | plain load/store, LR or SC write on the bus
// ST_AMO_RD | AMO read of the old word
// ST_AMO_WR | AMO write of op(old, rs2)
// ST_DONE   | result valid, stall released, always back to ST_IDLE
module mem_stage_controller
  import mem_defs::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_rs2_data_forwarded,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [2:0]  mem_mem_op_length,
  input  logic [4:0]  mem_atomic_op,
  mem_stage_controller_if.master bus,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_misaligned
);

  mem_state_t state;
  logic       pending;
  logic       mis;
  logic       wr_access;
  logic [2:0] eff_len;

  assign pending = mem_mem_read | mem_mem_write;
  assign mis     = is_misaligned(eff_len, mem_result[1:0]);

`ifdef MEM_ATOMIC_EN
  logic        is_atomic, is_lr, is_sc, is_rmw;
  logic        resv_valid, resv_hit;
  logic [29:0] resv_addr;
  logic [31:0] amo_new;

  assign is_atomic = mem_atomic_op != ATOMIC_NO_OP;
  assign is_lr     = is_atomic && (mem_atomic_op == ATOMIC_LR);
  assign is_sc     = is_atomic && (mem_atomic_op == ATOMIC_SC);
  assign is_rmw    = is_atomic && !is_lr && !is_sc;
  // Atomics are always word accesses regardless of the funct3 presented.
  assign eff_len   = is_atomic ? LEN_W : mem_mem_op_length;
  assign wr_access = is_sc || (!is_atomic && mem_mem_write && !mem_mem_read);
  assign resv_hit  = resv_valid && (resv_addr == mem_result[31:2]);

  amo_alu u_amo_alu (
    .old    (bus.bus_rdata),
    .rs2    (mem_rs2_data_forwarded),
    .funct5 (mem_atomic_op),
    .result (amo_new)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (state == ST_IDLE && pending && is_sc) begin
      resv_valid <= 1'b0;
    end else if (state == ST_ACCESS && bus.bus_ready && !bus.bus_we && is_lr) begin
      resv_valid <= 1'b1;
      resv_addr  <= mem_result[31:2];
    end else if (((state == ST_ACCESS && bus.bus_we) || state == ST_AMO_WR) && bus.bus_ready
                 && bus.bus_addr[31:2] == resv_addr) begin
      resv_valid <= 1'b0;
    end
  end
`else
  logic unused_atomic;
  assign unused_atomic = ^mem_atomic_op;
  assign eff_len       = mem_mem_op_length;
  assign wr_access     = mem_mem_write && !mem_mem_read;
`endif

  assign mem_stall = (state == ST_IDLE && pending) || state == ST_ACCESS
                     || state == ST_AMO_RD || state == ST_AMO_WR;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      bus.bus_req    <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_wdata  <= '0;
      bus.bus_wstrb  <= '0;
      mem_load_data  <= '0;
      mem_misaligned <= 1'b0;
    end else begin
      mem_misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pending) begin
            if (mis) begin
              state          <= ST_DONE;
              mem_misaligned <= 1'b1;
              mem_load_data  <= '0;
            end
`ifdef MEM_ATOMIC_EN
            else if (is_sc && !resv_hit) begin
              state         <= ST_DONE;
              mem_load_data <= 32'd1;
            end else if (is_rmw) begin
              state         <= ST_AMO_RD;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= 1'b0;
              bus.bus_addr  <= {mem_result[31:2], 2'b00};
              bus.bus_wdata <= '0;
              bus.bus_wstrb <= '0;
            end
`endif
            else begin
              state         <= ST_ACCESS;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= wr_access;
              bus.bus_addr  <= {mem_result[31:2], 2'b00};
              bus.bus_wdata <= wr_access ? store_data(mem_rs2_data_forwarded, eff_len) : '0;
              bus.bus_wstrb <= wr_access ? store_strb(mem_result[1:0], eff_len) : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (bus.bus_ready) begin
            state         <= ST_DONE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            // Stores (and a successful SC) report 0.
            mem_load_data <= bus.bus_we ? '0
                                        : load_align(bus.bus_rdata, mem_result[1:0], eff_len);
          end
        end
`ifdef MEM_ATOMIC_EN
        ST_AMO_RD: begin
          if (bus.bus_ready) begin
            state         <= ST_AMO_WR;
            mem_load_data <= bus.bus_rdata;
            bus.bus_we    <= 1'b1;
            bus.bus_wdata <= amo_new;
            bus.bus_wstrb <= 4'b1111;
          end
        end
        ST_AMO_WR: begin
          if (bus.bus_ready) begin
            state       <= ST_DONE;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller with a wait-state bus responder and a
// scoreboard queue of expected results; AMO/LR/SC steps build with MEM_ATOMIC_EN.
module tb_mem_stage_controller;
  import mem_defs::*;

  logic        clock;
  logic        reset_n;
  logic [31:0] mem_result;
  logic [31:0] mem_rs2_data_forwarded;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [2:0]  mem_mem_op_length;
  logic [4:0]  mem_atomic_op;
  logic        mem_stall;
  logic [31:0] mem_load_data;
  logic        mem_misaligned;

  mem_stage_controller_if bif ();

  mem_stage_controller dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .mem_result             (mem_result),
    .mem_rs2_data_forwarded (mem_rs2_data_forwarded),
    .mem_mem_read           (mem_mem_read),
    .mem_mem_write          (mem_mem_write),
    .mem_mem_op_length      (mem_mem_op_length),
    .mem_atomic_op          (mem_atomic_op),
    .bus                    (bif),
    .mem_stall              (mem_stall),
    .mem_load_data          (mem_load_data),
    .mem_misaligned         (mem_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    logic        mis;
    int          stall;
    int          txns;
    int          writes;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] waddr;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int fails   = 0;

  int          wait_n  = 0;
  logic [31:0] rd_word = '0;
  int          txns    = 0;
  int          writes  = 0;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus responder: grants after wait_n wait cycles, logs writes, checks stability.
  initial begin : responder
    int cnt;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    cnt = 0;
    s_we = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge clock);
      if (bif.bus_req === 1'b1) begin
        if (cnt == 0) begin
          s_we = bif.bus_we; s_addr = bif.bus_addr;
          s_wdata = bif.bus_wdata; s_wstrb = bif.bus_wstrb;
        end else begin
          check("stable we", 32'(bif.bus_we), 32'(s_we));
          check("stable addr", bif.bus_addr, s_addr);
          check("stable wdata", bif.bus_wdata, s_wdata);
          check("stable wstrb", 32'(bif.bus_wstrb), 32'(s_wstrb));
        end
        if (cnt >= wait_n) begin
          bif.bus_ready = 1'b1;
          bif.bus_rdata = rd_word;
          txns++;
          if (bif.bus_we === 1'b1) begin
            writes++;
            w_addr = bif.bus_addr; w_data = bif.bus_wdata; w_strb = bif.bus_wstrb;
          end
          cnt = 0;
        end else begin
          bif.bus_ready = 1'b0;
          cnt++;
        end
      end else begin
        bif.bus_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] len,
                        input logic [4:0] amo, input logic [31:0] addr, input logic [31:0] rs2,
                        input int waits, input logic [31:0] rword,
                        input logic chk, input logic [31:0] exp_data, input logic exp_mis,
                        input int exp_stall, input int exp_txns, input int exp_writes,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    exp_t e;
    int n, t0, w0;
    e.chk = chk; e.data = exp_data; e.mis = exp_mis; e.stall = exp_stall;
    e.txns = exp_txns; e.writes = exp_writes; e.wdata = exp_wdata; e.wstrb = exp_wstrb;
    e.waddr = {addr[31:2], 2'b00};
    exp_q.push_back(e);
    wait_n = waits; rd_word = rword; t0 = txns; w0 = writes;
    mem_result = addr; mem_rs2_data_forwarded = rs2; mem_mem_op_length = len;
    mem_atomic_op = amo; mem_mem_read = rd; mem_mem_write = wr;
    #1;
    n = 0;
    while (mem_stall === 1'b1 && n < 64) begin
      n++;
      @(negedge clock);
    end
    e = exp_q.pop_front();
    check({tag, " stall"}, 32'(n), 32'(e.stall));
    if (e.chk) check({tag, " data"}, mem_load_data, e.data);
    check({tag, " misaligned"}, 32'(mem_misaligned), 32'(e.mis));
    check({tag, " bus txns"}, 32'(txns - t0), 32'(e.txns));
    check({tag, " bus writes"}, 32'(writes - w0), 32'(e.writes));
    if (e.writes > 0) begin
      check({tag, " wdata"}, w_data, e.wdata);
      check({tag, " wstrb"}, 32'(w_strb), 32'(e.wstrb));
      check({tag, " waddr"}, w_addr, e.waddr);
    end
    mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_atomic_op = ATOMIC_NO_OP;
    @(negedge clock);
    check({tag, " misaligned cleared"}, 32'(mem_misaligned), 32'd0);
    check({tag, " idle stall"}, 32'(mem_stall), 32'd0);
  endtask

  initial begin : stimulus
    int n;
    reset_n = 1'b0;
    mem_result = '0; mem_rs2_data_forwarded = '0;
    mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    mem_mem_op_length = LEN_W; mem_atomic_op = ATOMIC_NO_OP;
    repeat (2) @(negedge clock);
    check("reset bus_req", 32'(bif.bus_req), 32'd0);
    check("reset bus_we", 32'(bif.bus_we), 32'd0);
    check("reset bus_addr", bif.bus_addr, 32'd0);
    check("reset bus_wdata", bif.bus_wdata, 32'd0);
    check("reset bus_wstrb", 32'(bif.bus_wstrb), 32'd0);
    check("reset stall", 32'(mem_stall), 32'd0);
    check("reset load_data", mem_load_data, 32'd0);
    check("reset misaligned", 32'(mem_misaligned), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    //      tag         rd wr len     amo           addr      rs2           wt rword          chk data          mis st tx wr wdata          wstrb
    run_op("lw wait2",  1, 0, LEN_W,  ATOMIC_NO_OP, 32'h100, 32'h0,         2, 32'hDEADBEEF,  1, 32'hDEADBEEF,  0, 4, 1, 0, 32'h0,         4'h0);
    run_op("lb",        1, 0, LEN_B,  ATOMIC_NO_OP, 32'h103, 32'h0,         0, 32'h80FFFFFF,  1, 32'hFFFFFF80,  0, 2, 1, 0, 32'h0,         4'h0);
    run_op("lbu",       1, 0, LEN_BU, ATOMIC_NO_OP, 32'h103, 32'h0,         0, 32'h80FFFFFF,  1, 32'h00000080,  0, 2, 1, 0, 32'h0,         4'h0);
    run_op("lh",        1, 0, LEN_H,  ATOMIC_NO_OP, 32'h102, 32'h0,         0, 32'h80011234,  1, 32'hFFFF8001,  0, 2, 1, 0, 32'h0,         4'h0);
    run_op("lhu",       1, 0, LEN_HU, ATOMIC_NO_OP, 32'h102, 32'h0,         1, 32'h80011234,  1, 32'h00008001,  0, 3, 1, 0, 32'h0,         4'h0);
    run_op("sh",        0, 1, LEN_H,  ATOMIC_NO_OP, 32'h102, 32'h1234ABCD,  0, 32'h0,         0, 32'h0,         0, 2, 1, 1, 32'hABCDABCD,  4'b1100);
    run_op("sb",        0, 1, LEN_B,  ATOMIC_NO_OP, 32'h101, 32'h0000005A,  0, 32'h0,         0, 32'h0,         0, 2, 1, 1, 32'h5A5A5A5A,  4'b0010);
    run_op("sw wait1",  0, 1, LEN_W,  ATOMIC_NO_OP, 32'h104, 32'hCAFEF00D,  1, 32'h0,         0, 32'h0,         0, 3, 1, 1, 32'hCAFEF00D,  4'b1111);
    run_op("lw mis",    1, 0, LEN_W,  ATOMIC_NO_OP, 32'h101, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 0, 0, 32'h0,         4'h0);
    run_op("sh mis",    0, 1, LEN_H,  ATOMIC_NO_OP, 32'h103, 32'h1111,      0, 32'h0,         0, 32'h0,         1, 1, 0, 0, 32'h0,         4'h0);
    run_op("rd+wr",     1, 1, LEN_W,  ATOMIC_NO_OP, 32'h108, 32'h99,        0, 32'h12345678,  1, 32'h12345678,  0, 2, 1, 0, 32'h0,         4'h0);

`ifdef MEM_ATOMIC_EN
    run_op("amoadd",    1, 1, LEN_W,  ATOMIC_ADD,   32'h200, 32'd7,         0, 32'd5,         1, 32'd5,         0, 3, 2, 1, 32'd12,        4'hF);
    run_op("amomax",    1, 1, LEN_W,  ATOMIC_MAX,   32'h204, 32'd3,         0, 32'hFFFFFFFF,  1, 32'hFFFFFFFF,  0, 3, 2, 1, 32'd3,         4'hF);
    run_op("amomin",    1, 1, LEN_W,  ATOMIC_MIN,   32'h204, 32'd3,         0, 32'hFFFFFFFF,  1, 32'hFFFFFFFF,  0, 3, 2, 1, 32'hFFFFFFFF,  4'hF);
    run_op("amominu",   1, 1, LEN_W,  ATOMIC_MINU,  32'h208, 32'd3,         0, 32'hFFFFFFFF,  1, 32'hFFFFFFFF,  0, 3, 2, 1, 32'd3,         4'hF);
    run_op("amomaxu",   1, 1, LEN_W,  ATOMIC_MAXU,  32'h208, 32'd3,         0, 32'hFFFFFFFF,  1, 32'hFFFFFFFF,  0, 3, 2, 1, 32'hFFFFFFFF,  4'hF);
    run_op("amoxor",    1, 1, LEN_W,  ATOMIC_XOR,   32'h20C, 32'h0000FF00,  0, 32'h0000F0F0,  1, 32'h0000F0F0,  0, 3, 2, 1, 32'h00000FF0,  4'hF);
    run_op("amoswap w1",1, 1, LEN_W,  ATOMIC_SWAP,  32'h210, 32'hA5A5A5A5,  1, 32'h01020304,  1, 32'h01020304,  0, 5, 2, 1, 32'hA5A5A5A5,  4'hF);
    run_op("amo mis",   1, 1, LEN_W,  ATOMIC_ADD,   32'h212, 32'd1,         0, 32'h0,         0, 32'h0,         1, 1, 0, 0, 32'h0,         4'h0);
    run_op("lr",        1, 0, LEN_W,  ATOMIC_LR,    32'h300, 32'h0,         0, 32'h0000AAAA,  1, 32'h0000AAAA,  0, 2, 1, 0, 32'h0,         4'h0);
    run_op("sc ok",     0, 1, LEN_W,  ATOMIC_SC,    32'h300, 32'h55,        0, 32'h0,         1, 32'd0,         0, 2, 1, 1, 32'h55,        4'hF);
    run_op("sc again",  0, 1, LEN_W,  ATOMIC_SC,    32'h300, 32'h66,        0, 32'h0,         1, 32'd1,         0, 1, 0, 0, 32'h0,         4'h0);
    run_op("lr2",       1, 0, LEN_W,  ATOMIC_LR,    32'h304, 32'h0,         0, 32'h77,        1, 32'h77,        0, 2, 1, 0, 32'h0,         4'h0);
    run_op("sw clr",    0, 1, LEN_W,  ATOMIC_NO_OP, 32'h304, 32'h88,        0, 32'h0,         0, 32'h0,         0, 2, 1, 1, 32'h88,        4'hF);
    run_op("sc cleared",0, 1, LEN_W,  ATOMIC_SC,    32'h304, 32'h99,        0, 32'h0,         1, 32'd1,         0, 1, 0, 0, 32'h0,         4'h0);
    run_op("lr3",       1, 0, LEN_W,  ATOMIC_LR,    32'h308, 32'h0,         0, 32'h1,         1, 32'h1,         0, 2, 1, 0, 32'h0,         4'h0);
    run_op("sw other",  0, 1, LEN_W,  ATOMIC_NO_OP, 32'h30C, 32'h2,         0, 32'h0,         0, 32'h0,         0, 2, 1, 1, 32'h2,         4'hF);
    run_op("sc kept",   0, 1, LEN_W,  ATOMIC_SC,    32'h308, 32'h3,         0, 32'h0,         1, 32'd0,         0, 2, 1, 1, 32'h3,         4'hF);
    run_op("lr4",       1, 0, LEN_W,  ATOMIC_LR,    32'h500, 32'h0,         0, 32'h4,         1, 32'h4,         0, 2, 1, 0, 32'h0,         4'h0);
`else
    run_op("amo ignored",1, 1, LEN_W, ATOMIC_ADD,   32'h200, 32'd7,         0, 32'd5,         1, 32'd5,         0, 2, 1, 0, 32'h0,         4'h0);
    run_op("sc ignored", 0, 1, LEN_B, ATOMIC_SC,    32'h301, 32'h77,        0, 32'h0,         0, 32'h0,         0, 2, 1, 1, 32'h77777777,  4'b0010);
`endif

    // Reset while a write is outstanding on the bus.
    wait_n = 6; rd_word = 32'h0;
    mem_result = 32'h400; mem_rs2_data_forwarded = 32'h99; mem_mem_op_length = LEN_W;
`ifdef MEM_ATOMIC_EN
    mem_atomic_op = ATOMIC_SWAP; mem_mem_read = 1'b1; mem_mem_write = 1'b1;
`else
    mem_atomic_op = ATOMIC_NO_OP; mem_mem_read = 1'b0; mem_mem_write = 1'b1;
`endif
    n = 0;
    while (!(bif.bus_req === 1'b1 && bif.bus_we === 1'b1) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("rst write reached", 32'(n < 40), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst bus_req", 32'(bif.bus_req), 32'd0);
    check("rst bus_we", 32'(bif.bus_we), 32'd0);
    check("rst bus_addr", bif.bus_addr, 32'd0);
    check("rst bus_wdata", bif.bus_wdata, 32'd0);
    check("rst bus_wstrb", 32'(bif.bus_wstrb), 32'd0);
    check("rst load_data", mem_load_data, 32'd0);
    mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_atomic_op = ATOMIC_NO_OP;
    @(negedge clock);
    check("rst stall", 32'(mem_stall), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
`ifdef MEM_ATOMIC_EN
    run_op("sc post rst",0, 1, LEN_W, ATOMIC_SC,    32'h500, 32'h5,         0, 32'h0,         1, 32'd1,         0, 1, 0, 0, 32'h0,         4'h0);
`endif
    run_op("lw post rst",1, 0, LEN_W, ATOMIC_NO_OP, 32'h10C, 32'h0,         0, 32'h0BADF00D,  1, 32'h0BADF00D,  0, 2, 1, 0, 32'h0,         4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
